// File: rtl/controle_medida_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : controle_medida_serial_if
//  Description : Measurement / UART handshake bundle for controle_medida_serial.
//  Revision    : 1.0 - initial release
// ============================================================================
interface controle_medida_serial_if;
   logic        ligar;
   logic        medida_pronto;
   logic [11:0] medida;
   logic        tx_pronto;
   logic        medir;
   logic        tx_partida;
   logic [6:0]  tx_dados;
   logic        fim_ciclo;
   logic [3:0]  db_estado;

   modport master (
      output ligar, medida_pronto, medida, tx_pronto,
      input  medir, tx_partida, tx_dados, fim_ciclo, db_estado
   );

   modport slave (
      input  ligar, medida_pronto, medida, tx_pronto,
      output medir, tx_partida, tx_dados, fim_ciclo, db_estado
   );
endinterface
`default_nettype wire

// File: rtl/controle_medida_serial.sv
`default_nettype none
// ============================================================================
//  Module      : controle_medida_serial
//  Description : Periodic HC-SR04 measure trigger; sends the BCD distance as
//                "CDU#" ASCII to the UART. Optional macro MEDIDA_TIMEOUT_EN
//                adds a measurement timeout that reports 12'hFFF ("???#").
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_medida_serial #(
   parameter int INTERVALO   = 50_000_000,
   parameter int TIMEOUT_MED = 5_000_000
) (
   input  wire logic               clock,
   input  wire logic               reset,
   controle_medida_serial_if.slave bus
);

   localparam int               CNT_W      = (INTERVALO > 2) ? $clog2(INTERVALO) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(INTERVALO - 1);

   if (INTERVALO < 2 || TIMEOUT_MED < 1) begin : g_param_check
      $error("controle_medida_serial: INTERVALO must be >= 2 and TIMEOUT_MED >= 1");
   end

   typedef enum logic [3:0] {
      INICIAL          = 4'h0,
      DISPARA          = 4'h1,
      ESPERA_MEDIDA    = 4'h2,
      REGISTRA         = 4'h3,
      ENVIA            = 4'h4,
      ESPERA_TX        = 4'h5,
      PROXIMO          = 4'h6,
      ESPERA_INTERVALO = 4'h7,
      FINAL_CICLO      = 4'hF
   } estado_t;

   estado_t          r_estado;
   estado_t          w_prox;
   logic [CNT_W-1:0] r_cnt;
   logic [11:0]      r_medida;
   logic [1:0]       r_idx;
   logic [6:0]       r_tx_dados;
   logic [1:0]       w_idx_prox;
   logic [3:0]       w_digito;
   logic [6:0]       w_char;
   logic             w_timeout;

`ifdef MEDIDA_TIMEOUT_EN
   localparam int               TMO_W      = (TIMEOUT_MED > 1) ? $clog2(TIMEOUT_MED) : 1;
   localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_MED - 1);

   logic [TMO_W-1:0] r_tmo;

   always_ff @(posedge clock) begin
      if (reset || r_estado != ESPERA_MEDIDA)
         r_tmo <= '0;
      else if (r_tmo != C_TMO_LAST)
         r_tmo <= r_tmo + 1'b1;
   end

   assign w_timeout = (r_estado == ESPERA_MEDIDA) && (r_tmo == C_TMO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset)
         r_estado <= INICIAL;
      else
         r_estado <= w_prox;
   end

   always_comb begin
      w_prox         = r_estado;
      bus.medir      = 1'b0;
      bus.tx_partida = 1'b0;
      bus.fim_ciclo  = 1'b0;
      bus.db_estado  = r_estado;
      case (r_estado)
         INICIAL:          if (bus.ligar) w_prox = DISPARA;
         DISPARA: begin
            bus.medir = 1'b1;
            w_prox    = ESPERA_MEDIDA;
         end
         ESPERA_MEDIDA:    if (bus.medida_pronto || w_timeout) w_prox = REGISTRA;
         REGISTRA:         w_prox = ENVIA;
         ENVIA: begin
            bus.tx_partida = 1'b1;
            w_prox         = ESPERA_TX;
         end
         ESPERA_TX:        if (bus.tx_pronto) w_prox = PROXIMO;
         PROXIMO:          w_prox = (r_idx == 2'd3) ? FINAL_CICLO : ENVIA;
         FINAL_CICLO: begin
            bus.fim_ciclo = 1'b1;
            w_prox        = ESPERA_INTERVALO;
         end
         ESPERA_INTERVALO: begin
            if (!bus.ligar)
               w_prox = INICIAL;
            else if (r_cnt == C_CNT_LAST)
               w_prox = DISPARA;
         end
         default: begin
            bus.db_estado = 4'hE;
            w_prox        = INICIAL;
         end
      endcase
   end

   // Character for the index about to be sent; envia is entered only from registra or proximo.
   always_comb begin
      w_idx_prox = (r_estado == REGISTRA) ? 2'd0 : r_idx + 2'd1;
      case (w_idx_prox)
         2'd0:    w_digito = r_medida[11:8];
         2'd1:    w_digito = r_medida[7:4];
         default: w_digito = r_medida[3:0];
      endcase
      if (w_idx_prox == 2'd3)
         w_char = 7'h23;
      else if (w_digito > 4'd9)
         w_char = 7'h3F;
      else
         w_char = 7'h30 + {3'b000, w_digito};
   end

   // Interval counter saturates so an overlong frame re-triggers right away.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt      <= '0;
         r_medida   <= '0;
         r_idx      <= '0;
         r_tx_dados <= '0;
      end else begin
         if (w_prox == DISPARA)
            r_cnt <= '0;
         else if (r_cnt != C_CNT_LAST)
            r_cnt <= r_cnt + 1'b1;

         if (r_estado == ESPERA_MEDIDA) begin
            if (bus.medida_pronto)
               r_medida <= bus.medida;
            else if (w_timeout)
               r_medida <= 12'hFFF;
         end

         if (w_prox == ENVIA) begin
            r_idx      <= w_idx_prox;
            r_tx_dados <= w_char;
         end
      end
   end

   assign bus.tx_dados = r_tx_dados;

endmodule
`default_nettype wire
